// File: rtl/bus_pkg.sv
// Shared constants, frame layout and helpers for the bus crossbar decoder.
// Frame = {sel, rw, addr, data}, MSB first; rw=1 write.
package bus_pkg;

  localparam int DEF_SEL_W  = 2;
  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 32;

  localparam int ADDR_LSB = DEF_DATA_W;
  localparam int RW_BIT   = ADDR_LSB + DEF_ADDR_W;
  localparam int SEL_LSB  = RW_BIT + 1;

  typedef struct packed {
    logic [DEF_SEL_W-1:0]  sel;
    logic                  rw;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } frame_t;

  // Field offsets for non-default widths
  function automatic int addr_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int rw_bit(input int addr_w, input int data_w);
    return data_w + addr_w;
  endfunction

  function automatic int sel_lsb(input int addr_w, input int data_w);
    return data_w + addr_w + 1;
  endfunction

  // Counter only has to reach TIMEOUT-1
  function automatic int cnt_w(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/bus_slave_decode.sv
// Slave-id/rw decode into one-hot write/read enables.
// Id 0 and ids above NUM_SLAVES are flagged invalid.
module bus_slave_decode
  import bus_pkg::*;
#(
  parameter int NUM_SLAVES = 3,
  parameter int SEL_W      = 2
) (
  input  logic [SEL_W-1:0]      sel,
  input  logic                  rw,
  output logic [NUM_SLAVES-1:0] wen,
  output logic [NUM_SLAVES-1:0] ren,
  output logic                  invalid
);

  always_comb begin
    wen     = '0;
    ren     = '0;
    invalid = (sel == '0) || (int'(sel) > NUM_SLAVES);
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (int'(sel) == k + 1) begin
        wen[k] = rw;
        ren[k] = !rw;
      end
    end
  end

endmodule

// File: rtl/bus_xbar_decoder_n.sv
// N-master grant mux with capture stage and issue stage driving
// per-slave enables until ack or timeout.
module bus_xbar_decoder_n
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 3,
  parameter int SEL_W       = 2,
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 255,
  parameter int FRAME_W     = SEL_W + 1 + ADDR_W + DATA_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_MASTERS*FRAME_W-1:0] m_frame,
  input  logic [NUM_MASTERS-1:0]         m_valid,
  input  logic [NUM_MASTERS-1:0]         m_grant,
  output logic [NUM_MASTERS-1:0]         m_ready,
  output logic [ADDR_W-1:0]              s_addr,
  output logic [DATA_W-1:0]              s_wdata,
  output logic [NUM_SLAVES-1:0]          s_wen,
  output logic [NUM_SLAVES-1:0]          s_ren,
  input  logic [NUM_SLAVES-1:0]          s_ack,
  output logic                           dec_err,
  output logic                           tmo_err,
  output logic                           busy
);

  localparam int A_LSB = addr_lsb(DATA_W);
  localparam int R_BIT = rw_bit(ADDR_W, DATA_W);
  localparam int S_LSB = sel_lsb(ADDR_W, DATA_W);
  localparam int CW    = cnt_w(TIMEOUT);

  logic [NUM_MASTERS-1:0] gnt_oh;
  logic [FRAME_W-1:0]     sel_frame;
  logic                   s1_valid;
  logic [FRAME_W-1:0]     s1_frame;
  logic                   s2_active;
  logic [CW-1:0]          cnt;
  logic [NUM_SLAVES-1:0]  dec_wen;
  logic [NUM_SLAVES-1:0]  dec_ren;
  logic                   dec_bad;
  logic                   ack_hit;
  logic                   tmo_hit;
  logic                   done;
  logic                   s1_adv;
  logic                   accept;

  // Descending scan: lowest-index grant bit wins
  always_comb begin
    gnt_oh    = '0;
    sel_frame = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (m_grant[i]) begin
        gnt_oh    = '0;
        gnt_oh[i] = 1'b1;
        sel_frame = m_frame[i*FRAME_W +: FRAME_W];
      end
    end
  end

  bus_slave_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_W      (SEL_W)
  ) u_dec (
    .sel     (s1_frame[S_LSB +: SEL_W]),
    .rw      (s1_frame[R_BIT]),
    .wen     (dec_wen),
    .ren     (dec_ren),
    .invalid (dec_bad)
  );

  always_comb begin
    ack_hit = s2_active && (|(s_ack & (s_wen | s_ren)));
    tmo_hit = (TIMEOUT > 0) && s2_active && !ack_hit
              && (int'(cnt) == TIMEOUT - 1);
    done    = ack_hit || tmo_hit;
    s1_adv  = s1_valid && (!s2_active || done);
    m_ready = gnt_oh & {NUM_MASTERS{!s1_valid || s1_adv}};
    accept  = |(m_valid & m_ready);
    busy    = s1_valid || s2_active;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_frame <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_frame <= sel_frame;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_active <= 1'b0;
      s_wen     <= '0;
      s_ren     <= '0;
      s_addr    <= '0;
      s_wdata   <= '0;
      cnt       <= '0;
      dec_err   <= 1'b0;
      tmo_err   <= 1'b0;
    end else begin
      dec_err <= s1_adv && dec_bad;
      tmo_err <= tmo_hit;
      if (s1_adv && !dec_bad) begin
        s2_active <= 1'b1;
        s_wen     <= dec_wen;
        s_ren     <= dec_ren;
        s_addr    <= s1_frame[A_LSB +: ADDR_W];
        s_wdata   <= s1_frame[DATA_W-1:0];
        cnt       <= '0;
      end else if (done || s1_adv) begin
        // Completion, abort, or a dropped bad frame leaves S2 idle
        s2_active <= 1'b0;
        s_wen     <= '0;
        s_ren     <= '0;
      end else if (s2_active) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bus_xbar_decoder_n.sv
// Directed bench for bus_xbar_decoder_n: 2 masters, 2 slaves,
// TIMEOUT=4 so both invalid ids and the ack timeout are reachable.
module tb_bus_xbar_decoder_n;
  import bus_pkg::*;

  localparam int NM = 2;
  localparam int NS = 2;
  localparam int FW = DEF_SEL_W + 1 + DEF_ADDR_W + DEF_DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NM*FW-1:0]  m_frame;
  logic [NM-1:0]     m_valid = '0;
  logic [NM-1:0]     m_grant = '0;
  logic [NM-1:0]     m_ready;
  logic [12:0]       s_addr;
  logic [31:0]       s_wdata;
  logic [NS-1:0]     s_wen;
  logic [NS-1:0]     s_ren;
  logic [NS-1:0]     s_ack = '0;
  logic              dec_err;
  logic              tmo_err;
  logic              busy;

  frame_t f0, f1;
  int n_tests = 0;
  int n_fail  = 0;

  assign m_frame = {f1, f0};

  always #5 clk = ~clk;

  bus_xbar_decoder_n #(
    .NUM_MASTERS (NM),
    .NUM_SLAVES  (NS),
    .SEL_W       (2),
    .ADDR_W      (13),
    .DATA_W      (32),
    .TIMEOUT     (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_frame (m_frame),
    .m_valid (m_valid),
    .m_grant (m_grant),
    .m_ready (m_ready),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_wen   (s_wen),
    .s_ren   (s_ren),
    .s_ack   (s_ack),
    .dec_err (dec_err),
    .tmo_err (tmo_err),
    .busy    (busy)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    f0 = '0;
    f1 = '0;
    #2;
    check("rst_wen", s_wen, 0);
    check("rst_ren", s_ren, 0);
    check("rst_busy", busy, 0);
    check("rst_derr", dec_err, 0);
    check("rst_terr", tmo_err, 0);
    check("rst_rdy", m_ready, 0);
    tick();
    rst = 1'b0;
    tick();

    // single write, master 0 -> slave 1
    f0 = '{sel: 2'd1, rw: 1'b1, addr: 13'h0A5, data: 32'hDEADBEEF};
    m_grant = 2'b01;
    m_valid = 2'b01;
    #1;
    check("w_rdy", m_ready, 2'b01);
    tick();
    m_valid = 2'b00;
    check("w_lat1", s_wen, 0);
    check("w_busy", busy, 1);
    tick();
    check("w_wen", s_wen, 2'b01);
    check("w_addr", s_addr, 13'h0A5);
    check("w_data", s_wdata, 32'hDEADBEEF);
    tick();
    tick();
    check("w_hold", s_wen, 2'b01);
    s_ack = 2'b01;
    tick();
    s_ack = 2'b00;
    check("w_done", s_wen, 0);
    check("w_idle", busy, 0);
    check("w_noterr", tmo_err, 0);

    // master 1 read -> slave 2, wrong-slave ack ignored
    f1 = '{sel: 2'd2, rw: 1'b0, addr: 13'h1FF, data: 32'h0};
    m_grant = 2'b10;
    m_valid = 2'b10;
    #1;
    check("r_rdy", m_ready, 2'b10);
    tick();
    m_valid = 2'b00;
    tick();
    check("r_ren", s_ren, 2'b10);
    check("r_wen", s_wen, 0);
    check("r_addr", s_addr, 13'h1FF);
    s_ack = 2'b01;
    tick();
    check("r_wrongack", s_ren, 2'b10);
    s_ack = 2'b10;
    tick();
    s_ack = 2'b00;
    check("r_done", s_ren, 0);
    check("r_idle", busy, 0);

    // back-to-back writes to slave 2 with ack tied high
    m_grant = 2'b01;
    s_ack = 2'b10;
    for (int i = 0; i < 6; i++) begin
      f0 = '{sel: 2'd2, rw: 1'b1, addr: 13'(i), data: 32'(i)};
      m_valid = (i < 4) ? 2'b01 : 2'b00;
      #1;
      if (i < 4) check($sformatf("b2b_rdy%0d", i), m_ready, 2'b01);
      if (i >= 2) begin
        check($sformatf("b2b_wen%0d", i), s_wen, 2'b10);
        check($sformatf("b2b_addr%0d", i), s_addr, 13'(i - 2));
      end
      tick();
    end
    check("b2b_end", s_wen, 0);
    s_ack = 2'b00;

    // invalid ids 0 and 3 (only 2 slaves)
    for (int j = 0; j < 2; j++) begin
      f0 = '{sel: (j == 0) ? 2'd0 : 2'd3, rw: 1'b1,
             addr: 13'h7, data: 32'h7};
      m_valid = 2'b01;
      tick();
      m_valid = 2'b00;
      check($sformatf("bad%0d_pre", j), dec_err, 0);
      tick();
      check($sformatf("bad%0d_err", j), dec_err, 1);
      check($sformatf("bad%0d_wen", j), s_wen, 0);
      check($sformatf("bad%0d_ren", j), s_ren, 0);
      check($sformatf("bad%0d_busy", j), busy, 0);
      tick();
      check($sformatf("bad%0d_pulse", j), dec_err, 0);
    end

    // valid read after bad ids, then timeout with a queued write
    f0 = '{sel: 2'd1, rw: 1'b0, addr: 13'h123, data: 32'h0};
    m_valid = 2'b01;
    tick();
    m_valid = 2'b00;
    tick();
    check("t_ren1", s_ren, 2'b01);
    check("t_addr", s_addr, 13'h123);
    f0 = '{sel: 2'd2, rw: 1'b1, addr: 13'h055, data: 32'hCAFE};
    m_valid = 2'b01;
    #1;
    check("t_qrdy", m_ready, 2'b01);
    tick();
    m_valid = 2'b00;
    check("t_ren2", s_ren, 2'b01);
    check("t_noterr2", tmo_err, 0);
    tick();
    check("t_ren3", s_ren, 2'b01);
    check("t_full", m_ready, 0);
    tick();
    check("t_ren4", s_ren, 2'b01);
    check("t_noterr4", tmo_err, 0);
    tick();
    check("t_terr", tmo_err, 1);
    check("t_ren_off", s_ren, 0);
    check("t_next_wen", s_wen, 2'b10);
    check("t_next_addr", s_addr, 13'h055);
    tick();
    check("t_pulse", tmo_err, 0);
    check("t_next_hold", s_wen, 2'b10);

    // async reset between edges while active
    #2;
    rst = 1'b1;
    #1;
    check("ar_wen", s_wen, 0);
    check("ar_ren", s_ren, 0);
    check("ar_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("ar_rdy", m_ready, 2'b01);
    tick();
    check("ar_derr", dec_err, 0);
    check("ar_terr", tmo_err, 0);
    check("ar_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
